// File: rtl/mul_product_serializer.sv
// Captures one PW-bit product per handshake and drains it LSB-nibble first, one nibble per cycle.
// Optional sign flag output is built only when MUL_SER_SIGN_EN is defined.
module mul_product_serializer #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_sign,
  input  logic          hold,
  output logic [3:0]    out_nib,
  output logic          out_rdy,
  output logic          out_first,
  output logic          out_last,
  output logic          out_sign
);

  localparam int unsigned NN = PW / 4;
  localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NN - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e        r_state, w_state_nxt;
  logic [PW-1:0] r_shift, w_shift_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic          w_busy, w_last, w_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_busy    = (r_state == StShift);
    w_last    = w_busy && (r_idx == LastIdx);
    in_ready  = !w_busy || (w_last && !hold);
    w_accept  = in_valid && in_ready;
    out_rdy   = w_busy;
    out_nib   = w_busy ? r_shift[3:0] : 4'h0;
    out_first = w_busy && (r_idx == '0);
    out_last  = w_last;

    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    if (w_accept) begin
      w_state_nxt = StShift;
      w_shift_nxt = in_prod;
      w_idx_nxt   = '0;
    end else if (w_busy && !hold) begin
      if (w_last) begin
        w_state_nxt = StIdle;
        w_shift_nxt = '0;
        w_idx_nxt   = '0;
      end else begin
        w_shift_nxt = r_shift >> 4;
        w_idx_nxt   = r_idx + IW'(1);
      end
    end
  end

`ifdef MUL_SER_SIGN_EN
  logic r_sign;

  // A zero magnitude never carries a sign, so there is no negative zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_sign <= in_sign && (in_prod != '0);
    end
  end

  assign out_sign = w_busy && r_sign;
`else
  logic w_unused_sign;
  assign w_unused_sign = in_sign;
  assign out_sign      = 1'b0;
`endif

endmodule

// File: tb/tb_mul_product_serializer.sv
// Bench for mul_product_serializer: queue-based nibble-stream model on a PW=8 instance,
// plus directed checks on PW=8, PW=16 and PW=4 instances.
module tb_mul_product_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // PW=8 instance (model-checked)
  logic       rst8 = 1'b0, valid8 = 1'b0, sign8 = 1'b0, hold8 = 1'b0;
  logic [7:0] prod8 = '0;
  logic       ready8, rdy8, first8, last8, osign8;
  logic [3:0] nib8;

  mul_product_serializer #(.PW(8)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(valid8), .in_ready(ready8), .in_prod(prod8),
    .in_sign(sign8), .hold(hold8), .out_nib(nib8), .out_rdy(rdy8), .out_first(first8),
    .out_last(last8), .out_sign(osign8)
  );

  // PW=16 instance
  logic        rst16 = 1'b0, valid16 = 1'b0, hold16 = 1'b0;
  logic [15:0] prod16 = '0;
  logic        ready16, rdy16, first16, last16, osign16;
  logic [3:0]  nib16;

  mul_product_serializer #(.PW(16)) u_dut16 (
    .clk(clk), .rst(rst16), .in_valid(valid16), .in_ready(ready16), .in_prod(prod16),
    .in_sign(1'b1), .hold(hold16), .out_nib(nib16), .out_rdy(rdy16), .out_first(first16),
    .out_last(last16), .out_sign(osign16)
  );

  // PW=4 instance
  logic       rst4 = 1'b0, valid4 = 1'b0;
  logic [3:0] prod4 = '0;
  logic       ready4, rdy4, first4, last4, osign4;
  logic [3:0] nib4;

  mul_product_serializer #(.PW(4)) u_dut4 (
    .clk(clk), .rst(rst4), .in_valid(valid4), .in_ready(ready4), .in_prod(prod4),
    .in_sign(1'b0), .hold(1'b0), .out_nib(nib4), .out_rdy(rdy4), .out_first(first4),
    .out_last(last4), .out_sign(osign4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: each accepted product becomes NN8 queued nibble records; the head is what is on the pins.
  typedef struct packed {
    logic [3:0] nib;
    logic       first;
    logic       last;
    logic       sign;
  } rec_t;

  localparam int NN8 = 2;
  rec_t q[$];

  function automatic bit model_ready();
    return (q.size() == 0) || (q.size() == 1 && !hold8);
  endfunction

  always @(posedge clk) begin
    if (!rst8) begin
      q.delete();
    end else begin
      bit acc;
      acc = valid8 && model_ready();
      if (q.size() > 0 && !hold8) void'(q.pop_front());
      if (acc) begin
        for (int k = 0; k < NN8; k++) begin
          rec_t r;
          r.nib   = 4'((prod8 >> (4 * k)) & 8'h0F);
          r.first = (k == 0);
          r.last  = (k == NN8 - 1);
`ifdef MUL_SER_SIGN_EN
          r.sign  = sign8 && (prod8 != 8'h00);
`else
          r.sign  = 1'b0;
`endif
          q.push_back(r);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      rec_t h;
      h = (q.size() > 0) ? q[0] : '0;
      check("model in_ready", 32'(ready8), 32'(model_ready()));
      check("model out_rdy", 32'(rdy8), 32'(q.size() > 0));
      check("model out_nib", 32'(nib8), 32'(h.nib));
      check("model out_first", 32'(first8), 32'(h.first));
      check("model out_last", 32'(last8), 32'(h.last));
      check("model out_sign", 32'(osign8), 32'(h.sign));
    end
  end

  initial begin
    #12;
    // Reset state, all instances
    check("rst8 in_ready", 32'(ready8), 32'd1);
    check("rst8 out_rdy", 32'(rdy8), 32'd0);
    check("rst8 out_nib", 32'(nib8), 32'd0);
    check("rst16 in_ready", 32'(ready16), 32'd1);
    check("rst4 out_rdy", 32'(rdy4), 32'd0);
    step();
    rst8 = 1'b1; rst16 = 1'b1; rst4 = 1'b1;
    chk_en = 1'b1;
    step();

    // Single frame 0x9C
    valid8 = 1'b1; prod8 = 8'h9C;
    step();
    valid8 = 1'b0;
    @(negedge clk);
    check("9C n0 nib", 32'(nib8), 32'hC);
    check("9C n0 first", 32'(first8), 32'd1);
    check("9C n0 rdy", 32'(rdy8), 32'd1);
    step();
    @(negedge clk);
    check("9C n1 nib", 32'(nib8), 32'h9);
    check("9C n1 last", 32'(last8), 32'd1);
    step();
    @(negedge clk);
    check("9C done rdy", 32'(rdy8), 32'd0);
    check("9C done in_ready", 32'(ready8), 32'd1);

    // Hold stall on nibble 0
    valid8 = 1'b1; prod8 = 8'h9C;
    step();
    valid8 = 1'b0; hold8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold nib", 32'(nib8), 32'hC);
      check("hold in_ready", 32'(ready8), 32'd0);
      step();
    end
    hold8 = 1'b0;
    @(negedge clk);
    check("unhold nib0", 32'(nib8), 32'hC);
    step();
    @(negedge clk);
    check("unhold nib1", 32'(nib8), 32'h9);
    step();
    @(negedge clk);
    check("unhold idle", 32'(rdy8), 32'd0);

    // Back-to-back 0x21, 0x43
    valid8 = 1'b1; prod8 = 8'h21;
    step();
    valid8 = 1'b0;
    @(negedge clk);
    check("b2b nib 1", 32'(nib8), 32'h1);
    check("b2b first", 32'(first8), 32'd1);
    step();
    valid8 = 1'b1; prod8 = 8'h43;
    @(negedge clk);
    check("b2b nib 2", 32'(nib8), 32'h2);
    check("b2b in_ready on last", 32'(ready8), 32'd1);
    step();
    valid8 = 1'b0;
    @(negedge clk);
    check("b2b nib 3", 32'(nib8), 32'h3);
    check("b2b rdy kept", 32'(rdy8), 32'd1);
    check("b2b first again", 32'(first8), 32'd1);
    step();
    @(negedge clk);
    check("b2b nib 4", 32'(nib8), 32'h4);
    check("b2b last", 32'(last8), 32'd1);
    step();

    // Sign flag
    valid8 = 1'b1; prod8 = 8'h06; sign8 = 1'b1;
    step();
    valid8 = 1'b0; sign8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
`ifdef MUL_SER_SIGN_EN
      check("sign neg", 32'(osign8), 32'd1);
`else
      check("sign tied", 32'(osign8), 32'd0);
`endif
      step();
    end
    valid8 = 1'b1; prod8 = 8'h00; sign8 = 1'b1;
    step();
    valid8 = 1'b0; sign8 = 1'b0;
    @(negedge clk);
    check("sign zero", 32'(osign8), 32'd0);
    step();
    step();

    // PW=16: async reset mid-frame
    valid16 = 1'b1; prod16 = 16'hBEEF;
    step();
    valid16 = 1'b0;
    @(negedge clk);
    check("16 nib F", 32'(nib16), 32'hF);
    #2 rst16 = 1'b0;
    #1;
    check("16 rst rdy", 32'(rdy16), 32'd0);
    check("16 rst nib", 32'(nib16), 32'd0);
    check("16 rst first", 32'(first16), 32'd0);
    check("16 rst in_ready", 32'(ready16), 32'd1);
    check("16 rst sign", 32'(osign16), 32'd0);
    step();
    rst16 = 1'b1;
    valid16 = 1'b1; prod16 = 16'h0001;
    step();
    valid16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("16 nib", 32'(nib16), (k == 0) ? 32'h1 : 32'h0);
      check("16 first", 32'(first16), 32'(k == 0));
      check("16 last", 32'(last16), 32'(k == 3));
      check("16 rdy", 32'(rdy16), 32'd1);
      step();
    end
    @(negedge clk);
    check("16 idle", 32'(rdy16), 32'd0);

    // PW=4: single-nibble frame
    valid4 = 1'b1; prod4 = 4'hA;
    step();
    valid4 = 1'b0;
    @(negedge clk);
    check("4 nib", 32'(nib4), 32'hA);
    check("4 first", 32'(first4), 32'd1);
    check("4 last", 32'(last4), 32'd1);
    check("4 in_ready", 32'(ready4), 32'd1);
    check("4 sign", 32'(osign4), 32'd0);
    step();
    @(negedge clk);
    check("4 idle", 32'(rdy4), 32'd0);

    // Random traffic on the PW=8 instance
    for (int i = 0; i < 3000; i++) begin
      step();
      valid8 = ($urandom_range(0, 1) == 1);
      prod8  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sign8  = ($urandom_range(0, 1) == 1);
      hold8  = ($urandom_range(0, 3) == 0);
    end
    step();
    valid8 = 1'b0; hold8 = 1'b0;
    step();
    step();
    step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
